pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges the load-use stall from the
//  hazard detection unit, EX branch/jump redirects, multi-cycle EX unit busy and data-memory wait
//  handshake into per-stage register enables and bubble (flush) controls. Tracks wait state for a
//  data-memory timeout watchdog and a halt/resume mechanism.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max consecutive MEM_WAIT cycles before mem_timeout is raised (>=2)
//  CNT_W           32   width of performance counters
// PORTS
//  clk             in   1      core clock, all state on rising edge
//  reset           in   1      synchronous, active-high reset
//  load_use_stall  in   1      hazard unit: ID needs load result still in EX
//  branch_taken_ex in   1      EX resolved taken branch/jump; PC loads target this cycle
//  mc_busy         in   1      multi-cycle EX unit (mul/div) still computing
//  dmem_req        in   1      MEM stage holds a load/store request
//  dmem_ready      in   1      data memory completes request this cycle
//  halt_req        in   1      WB retires ecall/ebreak (level, one cycle)
//  resume          in   1      external restart pulse
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1 each  stage register enables
//  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out 1 each  load NOP bubble into register
//  halted          out  1      state == ST_HALT
//  mem_timeout     out  1      sticky watchdog error
//  stall_count     out  CNT_W  cycles with pc_en==0 (PERF_CNT_EN only)
//  flush_count     out  CNT_W  redirect events (PERF_CNT_EN only)
// BEHAVIOUR
//  States (registered): ST_RUN, ST_MEM_WAIT, ST_MC_WAIT, ST_HALT. Outputs combinational from state+inputs.
//  Reset (and while reset high): all *_en=0, all *_flush=1, halted=0, mem_timeout=0, counters=0, state=ST_RUN.
//  Priority per cycle (highest first): HALT > mem freeze > mc freeze > branch redirect > load-use > run.
//  - mem freeze (dmem_req && !dmem_ready): pc/if_id/id_ex/ex_mem en=0, mem_wb_flush=1; next ST_MEM_WAIT.
//    In ST_MEM_WAIT a cycle with dmem_ready: all en=1, next ST_RUN (or ST_MC_WAIT if mc_busy).
//  - mc freeze (mc_busy): pc/if_id/id_ex en=0, ex_mem_flush=1, mem_wb_en=1; next ST_MC_WAIT;
//    exit to ST_RUN the cycle mc_busy falls (that cycle: all en=1).
//  - branch redirect: all en=1, if_id_flush=1, id_ex_flush=1 (2 bubbles). Overrides load_use_stall
//    (stalled instr is wrong-path). Ignored under freeze; frozen EX re-presents it afterwards.
//  - load-use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem/mem_wb en=1. One bubble per asserted cycle.
//  - run: all en=1, all flush=0.
//  - flush overrides enable for the same register (flush loads NOP even if en=0).
//  Watchdog: wait_cnt ($clog2(TIMEOUT_CYCLES) bits) increments each ST_MEM_WAIT cycle without
//    dmem_ready, clears on exit. At wait_cnt==TIMEOUT_CYCLES-1 with no ready: mem_timeout<=1 (sticky
//    until reset), next ST_HALT. Counter never wraps.
//  Halt: halt_req in any non-HALT state -> ST_HALT next cycle (if dmem_req pending, halt waits for
//    dmem_ready first). In ST_HALT all en=0, flush=0. resume -> ST_RUN next cycle, ignored if
//    mem_timeout=1. halt_req and resume same cycle in ST_HALT: resume wins.
//  Reset mid-wait/halt: immediate return to ST_RUN, wait_cnt=0.
// CONFIGURATION
//  PIPE_SEQ_PERF_CNT_EN defined: stall_count (+1 each cycle pc_en==0 outside reset/halt) and
//    flush_count (+1 each redirect) implemented, saturating at all-ones.
//  Not defined: stall_count, flush_count tied to 0; no counter flops.
// TESTING
//  1. load_use_stall 1 cycle in ST_RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; next cycle all en=1.
//  2. branch_taken_ex && load_use_stall same cycle -> if_id_flush=id_ex_flush=1, pc_en=1; flush_count 0->1.
//  3. dmem_req=1, dmem_ready low 3 cycles then high -> 3 cycles ex_mem_en=0, mem_wb_flush=1; 4th all en=1, ST_RUN.
//  4. TIMEOUT_CYCLES=4, dmem_ready never -> mem_timeout=1 after 4 wait cycles, halted=1; resume ignored.
//  5. mc_busy 5 cycles overlapping dmem stall in cycle 3 -> mem freeze wins cycle 3, stall_count=5.
//  6. halt_req in ST_RUN -> halted=1 next cycle, en=0; resume -> ST_RUN; reset during halt -> halted=0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Define PIPE_SEQ_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             branch_taken_ex,
  input  logic             mc_busy,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_MC_WAIT,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memTimeout_q, memTimeout_d;
  logic              haltPend_q, haltPend_d;

  logic memStall;
  logic redirect;
  logic wdFire;

  assign memStall = dmem_req && !dmem_ready;
  assign wdFire   = (state_q == ST_MEM_WAIT) && memStall && (waitCnt_q == WAIT_LAST);

  // Stage controls follow the fixed priority; the wait states only matter for next-state.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    redirect     = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (memStall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mc_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (branch_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect    = 1'b1;
    end else if (load_use_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // A halt request arriving behind an outstanding memory access is remembered until it completes.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = '0;
    memTimeout_d = memTimeout_q;
    haltPend_d   = haltPend_q;
    if (state_q == ST_HALT) begin
      haltPend_d = 1'b0;
      if (resume && !memTimeout_q) begin
        state_d = ST_RUN;
      end
    end else if (wdFire) begin
      memTimeout_d = 1'b1;
      haltPend_d   = 1'b0;
      state_d      = ST_HALT;
    end else if ((halt_req || haltPend_q) && !memStall) begin
      haltPend_d = 1'b0;
      state_d    = ST_HALT;
    end else if (memStall) begin
      haltPend_d = haltPend_q || halt_req;
      state_d    = ST_MEM_WAIT;
      if (state_q == ST_MEM_WAIT) begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
    end else if (mc_busy) begin
      state_d = ST_MC_WAIT;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      waitCnt_q    <= '0;
      memTimeout_q <= 1'b0;
      haltPend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      memTimeout_q <= memTimeout_d;
      haltPend_q   <= haltPend_d;
    end
  end

  assign halted      = !reset && (state_q == ST_HALT);
  assign mem_timeout = !reset && memTimeout_q;

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] flushCnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if ((state_q != ST_HALT) && !pc_en && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + 1'b1;
      end
      if (redirect && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + 1'b1;
      end
    end
  end

  assign stall_count = reset ? '0 : stallCnt_q;
  assign flush_count = reset ? '0 : flushCnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios then random traffic
// compared against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CW      = 6;
  localparam int SAT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_use_stall = 1'b0;
  logic          branch_taken_ex = 1'b0;
  logic          mc_busy = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          halted, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_use_stall(load_use_stall),
    .branch_taken_ex(branch_taken_ex),
    .mc_busy(mc_busy),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .halt_req(halt_req),
    .resume(resume),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush),
    .halted(halted),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  // Reference model: only tracks what changes future behaviour (halted, memory wait age,
  // a deferred halt, the sticky timeout) plus the two event tallies.
  bit mHalted, mTimedOut, mWaiting, mHaltPend;
  int mWaitCycles, mStall, mFlush;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic applyStimulus(input string tag, input bit rst, input bit lu, input bit br,
                               input bit mc, input bit dreq, input bit drdy,
                               input bit hreq, input bit res);
    logic [8:0] expCtrl;
    logic [8:0] obsCtrl;
    bit         memBlocked;
    int         expStall, expFlush;
    @(negedge clk);
    reset           = rst;
    load_use_stall  = lu;
    branch_taken_ex = br;
    mc_busy         = mc;
    dmem_req        = dreq;
    dmem_ready      = drdy;
    halt_req        = hreq;
    resume          = res;
    #1;
    memBlocked = dreq && !drdy;
    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
    if (rst)             expCtrl = 9'b00000_1111;
    else if (mHalted)    expCtrl = 9'b00000_0000;
    else if (memBlocked) expCtrl = 9'b00001_0001;
    else if (mc)         expCtrl = 9'b00011_0010;
    else if (br)         expCtrl = 9'b11111_1100;
    else if (lu)         expCtrl = 9'b00111_0100;
    else                 expCtrl = 9'b11111_0000;
    obsCtrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
`ifdef PIPE_SEQ_PERF_CNT_EN
    expStall = rst ? 0 : mStall;
    expFlush = rst ? 0 : mFlush;
`else
    expStall = 0;
    expFlush = 0;
`endif
    checkOutput({tag, " ctrl"}, 32'(obsCtrl), 32'(expCtrl));
    checkOutput({tag, " halted"}, 32'(halted), 32'(!rst && mHalted));
    checkOutput({tag, " mem_timeout"}, 32'(mem_timeout), 32'(!rst && mTimedOut));
    checkOutput({tag, " stall_count"}, 32'(stall_count), 32'(expStall));
    checkOutput({tag, " flush_count"}, 32'(flush_count), 32'(expFlush));

    if (rst) begin
      mHalted = 0; mTimedOut = 0; mWaiting = 0; mHaltPend = 0;
      mWaitCycles = 0; mStall = 0; mFlush = 0;
    end else if (mHalted) begin
      if (res && !mTimedOut) mHalted = 0;
    end else begin
      if (!expCtrl[8] && mStall < SAT_MAX) mStall++;
      if (!memBlocked && !mc && br && mFlush < SAT_MAX) mFlush++;
      if (mWaiting && memBlocked && mWaitCycles == TIMEOUT - 1) begin
        mTimedOut = 1; mHalted = 1; mWaiting = 0; mHaltPend = 0;
      end else if ((hreq || mHaltPend) && !memBlocked) begin
        mHalted = 1; mWaiting = 0; mHaltPend = 0;
      end else if (memBlocked) begin
        mHaltPend = mHaltPend || hreq;
        if (mWaiting) mWaitCycles++;
        else begin
          mWaiting = 1;
          mWaitCycles = 0;
        end
      end else begin
        mWaiting = 0;
      end
    end
  endtask

  initial begin
    //                       rst lu br mc rq rd hq rs
    applyStimulus("reset0",   1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1",   1, 1, 1, 1, 1, 0, 1, 1);
    applyStimulus("t1_lu",    0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("t1_after", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t2_brlu",  0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus("t2_after", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t3_w1",    0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus("t3_w2",    0, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus("t3_w3",    0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus("t3_rdy",   0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("t3_after", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t5_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t5_mc1",   0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("t5_mc2",   0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus("t5_mem",   0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus("t5_rdy",   0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus("t5_mc5",   0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus("t5_fall",  0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t5_count", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t6_hreq",  0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("t6_held",  0, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus("t6_both",  0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("t6_run",   0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t6_hreq2", 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("t6_held2", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t6_rst",   1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t6_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("hp_req",   0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus("hp_wait",  0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus("hp_rdy",   0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("hp_halt",  0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("hp_res",   0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      applyStimulus("t4_wait", 0, 0, 0, 0, 1, 0, 0, 0);
    end
    applyStimulus("t4_res",   0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("t4_stuck", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t4_rst",   1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t4_clear", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0,  $urandom_range(0, 4) == 0,
                    $urandom_range(0, 2) == 0,  $urandom_range(0, 1) == 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
